// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues imem requests under a credit
// limit, buffers in-order responses with their PCs and flushes on redirect.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int SW = CW + 2;

    logic [31:0]   pc;
    logic [31:0]   rsp_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] fifo_count;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [31:0]   fifo_instr [DEPTH];
    logic [31:0]   fifo_pc    [DEPTH];

    logic [SW-1:0] credit_used;
    logic          credit_ok;
    logic          req_fire;
    logic          pop;
    logic          rsp_drop;
    logic          rsp_keep;
    logic          rsp_error;
    logic          push;
    logic [31:0]   redirect_target;

    logic [CW-1:0] outstanding_nxt;
    logic [CW-1:0] drop_cnt_nxt;
    logic [CW-1:0] drop_cnt_redir;
    logic [CW-1:0] fifo_count_nxt;

    // Every accepted request reserves a FIFO slot until it is consumed or dropped.
    assign credit_used = SW'(outstanding) + SW'(fifo_count) + SW'(drop_cnt);
    assign credit_ok   = credit_used < SW'(DEPTH);

    assign imem_req_valid = rst_n & ~redirect_valid & credit_ok;
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid & imem_req_ready;

    assign instr_valid = rst_n & ~redirect_valid & (fifo_count != '0);
    assign instr       = fifo_instr[rd_ptr];
    assign instr_pc    = fifo_pc[rd_ptr];
    assign pop         = instr_valid & instr_ready;

    assign rsp_drop  = imem_rsp_valid & (drop_cnt != '0);
    assign rsp_keep  = imem_rsp_valid & (drop_cnt == '0) & (outstanding != '0);
    assign rsp_error = imem_rsp_valid & (drop_cnt == '0) & (outstanding == '0);
    assign push      = rsp_keep & ~redirect_valid;

    assign redirect_target = redirect_pc & ~32'd3;

    always_comb begin
        outstanding_nxt = outstanding;
        drop_cnt_nxt    = drop_cnt;
        drop_cnt_redir  = drop_cnt + outstanding;
        fifo_count_nxt  = fifo_count;
        if (req_fire) begin
            outstanding_nxt = outstanding_nxt + CW'(1);
        end
        if (rsp_keep) begin
            outstanding_nxt = outstanding_nxt - CW'(1);
        end
        if (rsp_drop) begin
            drop_cnt_nxt = drop_cnt - CW'(1);
        end
        // The response landing in a redirect cycle is stale either way.
        if (rsp_drop | rsp_keep) begin
            drop_cnt_redir = drop_cnt_redir - CW'(1);
        end
        if (push) begin
            fifo_count_nxt = fifo_count_nxt + CW'(1);
        end
        if (pop) begin
            fifo_count_nxt = fifo_count_nxt - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            fifo_count  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else if (redirect_valid) begin
            pc          <= redirect_target;
            rsp_pc      <= redirect_target;
            outstanding <= '0;
            drop_cnt    <= drop_cnt_redir;
            fifo_count  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            outstanding <= outstanding_nxt;
            drop_cnt    <= drop_cnt_nxt;
            fifo_count  <= fifo_count_nxt;
            if (req_fire) begin
                pc <= pc + 32'd4;
            end
            if (push) begin
                rsp_pc <= rsp_pc + 32'd4;
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr[wr_ptr] <= imem_rsp_data;
            fifo_pc[wr_ptr]    <= rsp_pc;
        end
    end

    // A response with nothing in flight means the memory broke the protocol.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!rsp_error);
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: memory model, stream-level reference
// model and a scoreboard monitor on the decode handshake.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int          DEPTH  = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    fetch_unit #(
        .RESET_PC(RST_PC),
        .DEPTH   (DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .instr_pc      (instr_pc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    typedef struct packed {
        logic [31:0] addr;
        int          due;
    } pend_t;

    exp_t  exp_q[$];
    pend_t pend_q[$];

    int checks = 0;
    int fails = 0;
    int cyc = 0;
    int last_due = 0;
    int delivered = 0;
    int p_rdy, p_irdy, p_redir, p_rst, lat_max;
    logic [31:0] model_pc = RST_PC;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC001_D00D;
    endfunction

    task automatic check32(input string name, input logic [31:0] act,
                           input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h (cycle %0d)",
                     name, act, req, cyc);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %b, required %b (cycle %0d)",
                     name, act, req, cyc);
        end
    endtask

    function automatic logic [31:0] pick_target();
        logic [31:0] t;
        case ($urandom_range(3))
            0: t = $urandom;
            1: t = 32'hFFFF_FFF0 | 32'($urandom_range(15));
            2: t = 32'h0000_2003;
            default: t = RST_PC + 32'($urandom_range(63));
        endcase
        return t;
    endfunction

    // Memory + stimulus driver: inputs change 1 time unit after the edge.
    task automatic drive_cycle();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect_valid = 1'b0;
        rst_n = !($urandom_range(999) < p_rst);
        if (!rst_n) begin
            pend_q.delete();
            last_due = cyc;
        end else if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend_q[0].addr);
            void'(pend_q.pop_front());
        end
        imem_req_ready = $urandom_range(99) < p_rdy;
        instr_ready    = $urandom_range(99) < p_irdy;
        if (rst_n && $urandom_range(999) < p_redir) begin
            redirect_valid = 1'b1;
            redirect_pc    = pick_target();
        end
    endtask

    // Reference model: the delivered stream is the accepted request stream,
    // with everything not yet delivered discarded on redirect or reset.
    always @(negedge clk) begin
        int d;
        if (!rst_n) begin
            check1("req_valid_in_reset", imem_req_valid, 1'b0);
            check1("instr_valid_in_reset", instr_valid, 1'b0);
            exp_q.delete();
            model_pc = RST_PC;
        end else if (redirect_valid) begin
            check1("req_valid_on_redirect", imem_req_valid, 1'b0);
            check1("instr_valid_on_redirect", instr_valid, 1'b0);
            exp_q.delete();
            model_pc = redirect_pc & ~32'd3;
        end else if (imem_req_valid && imem_req_ready) begin
            check32("req_addr", imem_req_addr, model_pc);
            exp_q.push_back('{pc: model_pc, word: mem_word(model_pc)});
            d = cyc + $urandom_range(lat_max, 1);
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            pend_q.push_back('{addr: imem_req_addr, due: d});
            check1("outstanding_limit", pend_q.size() <= DEPTH, 1'b1);
            check1("buffered_limit", exp_q.size() <= DEPTH, 1'b1);
            model_pc = model_pc + 32'd4;
        end
    end

    logic        prev_rst = 1'b1;
    logic        prev_iv_stall = 1'b0;
    logic        prev_rq_stall = 1'b0;
    logic [31:0] prev_instr, prev_ipc, prev_addr;

    // Monitor: pops the scoreboard on every decode handshake.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (prev_rst) check1("instr_valid_after_reset", instr_valid, 1'b0);
            if (prev_iv_stall && instr_valid) begin
                check32("instr_hold", instr, prev_instr);
                check32("instr_pc_hold", instr_pc, prev_ipc);
            end
            if (prev_rq_stall && imem_req_valid)
                check32("req_addr_hold", imem_req_addr, prev_addr);
            if (instr_valid && instr_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_instr: got pc %h, required none",
                             instr_pc);
                end else begin
                    e = exp_q.pop_front();
                    check32("instr_pc", instr_pc, e.pc);
                    check32("instr", instr, e.word);
                    delivered++;
                end
            end
        end
        prev_rst      = !rst_n;
        prev_iv_stall = rst_n && instr_valid && !instr_ready;
        prev_rq_stall = rst_n && imem_req_valid && !imem_req_ready;
        prev_instr    = instr;
        prev_ipc      = instr_pc;
        prev_addr     = imem_req_addr;
    end

    initial begin : stim
        int base;
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        instr_ready    = 1'b0;
        p_rdy = 100; p_irdy = 100; p_redir = 0; p_rst = 0; lat_max = 1;
        repeat (3) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        rst_n = 1'b1;
        for (int ph = 0; ph < 5; ph++) begin
            case (ph)
                0: begin p_rdy = 100; p_irdy = 100; p_redir = 0;   p_rst = 0;  lat_max = 1; end
                1: begin p_rdy = 70;  p_irdy = 20;  p_redir = 0;   p_rst = 0;  lat_max = 2; end
                2: begin p_rdy = 80;  p_irdy = 80;  p_redir = 60;  p_rst = 0;  lat_max = 3; end
                3: begin p_rdy = 60;  p_irdy = 60;  p_redir = 100; p_rst = 10; lat_max = 3; end
                default: begin p_rdy = 100; p_irdy = 100; p_redir = 30; p_rst = 5; lat_max = 1; end
            endcase
            base = delivered;
            for (int i = 0; i < 500; i++) begin
                @(posedge clk);
                #1;
                cyc++;
                drive_cycle();
            end
            if (ph == 0) begin
                checks++;
                if (delivered - base < 300) begin
                    fails++;
                    $display("FAIL steady_throughput: got %0d, required >= 300",
                             delivered - base);
                end
            end
        end
        checks++;
        if (delivered < 800) begin
            fails++;
            $display("FAIL progress: got %0d delivered, required >= 800",
                     delivered);
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
